// File: rtl/trivium_ks_xor.sv
// Keystream XOR stage: buffers 128-bit Trivium keystream words in a small FIFO and
// XORs them lane by lane (MSB lane first) onto a valid/ready plaintext stream.
module trivium_ks_xor #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          resync,
    input  logic [127:0]  ks_in,
    input  logic          ks_vld,
    output logic          ks_req,
    input  logic [DW-1:0] pt_in,
    input  logic          pt_vld,
    output logic          pt_rdy,
    output logic [DW-1:0] ct_out,
    output logic          ct_vld,
    input  logic          ct_rdy,
    output logic [15:0]   ct_cnt,
    output logic          ovf
);

    localparam int unsigned L  = 128 / DW;
    localparam int unsigned IW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [127:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] ct_out_q;
    logic          ct_vld_q;
    logic [15:0]   ct_cnt_q;
    logic          ovf_q;

    logic          fifo_empty, fifo_full;
    logic          accept, last_lane, pop, push, drop, ct_fire;
    logic [127:0]  head;
    logic [DW-1:0] lanes [L];
    logic [DW-1:0] lane;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));

    // resync blocks acceptance so a flushed cycle never emits a lane
    assign pt_rdy    = ~fifo_empty & (~ct_vld_q | ct_rdy) & ~resync;
    assign ks_req    = ~fifo_full;
    assign accept    = pt_vld & pt_rdy;
    assign last_lane = (idx_q == IW'(L - 1));
    assign pop       = accept & last_lane;
    // a pop frees the head slot in the same cycle, so a full FIFO can still take a word
    assign push      = ks_vld & ~resync & (~fifo_full | pop);
    assign drop      = ks_vld & ~resync & fifo_full & ~pop;
    assign ct_fire   = ct_vld_q & ct_rdy;

    assign head = mem_q[rd_ptr_q];

    for (genvar k = 0; k < L; k++) begin : g_lane
        assign lanes[k] = head[127 - k*DW -: DW];
    end

    assign lane = lanes[idx_q];

    // keystream storage, written at the tail
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ks_in;
        end
    end

    // FIFO pointers, occupancy, lane index and sticky overflow
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (resync) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (accept) begin
                idx_q <= last_lane ? '0 : idx_q + IW'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // registered ciphertext lane, valid flag and transfer counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ct_out_q <= '0;
            ct_vld_q <= 1'b0;
            ct_cnt_q <= '0;
        end else if (resync) begin
            ct_out_q <= '0;
            ct_vld_q <= 1'b0;
            ct_cnt_q <= '0;
        end else begin
            if (accept) begin
                ct_out_q <= pt_in ^ lane;
                ct_vld_q <= 1'b1;
            end else if (ct_fire) begin
                ct_vld_q <= 1'b0;
            end
            if (ct_fire) begin
                ct_cnt_q <= ct_cnt_q + 16'd1;
            end
        end
    end

    assign ct_out = ct_out_q;
    assign ct_vld = ct_vld_q;
    assign ct_cnt = ct_cnt_q;
    assign ovf    = ovf_q;

endmodule
